uart_tx_framed: RTL and testbench

//   Parametrised UART transmitter with an input FIFO and a valid/ready write port.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_framed.sv | 146 ++++++++++++++
 tb/tb_uart_tx_framed.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, tx FSM states, per-frame format.
// Pure declarations; the configurable receiver is expected to reuse these too.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic par_en;
    logic par_odd;
    logic stop2;
  } frame_cfg_t;

  // The reserved mode decodes as "no parity".
  function automatic frame_cfg_t decode_cfg(input logic [1:0] mode, input logic two_stop);
    frame_cfg_t cfg;
    cfg.par_en  = (mode == PAR_EVEN) || (mode == PAR_ODD);
    cfg.par_odd = (mode == PAR_ODD);
    cfg.stop2   = two_stop;
    return cfg;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock registered FIFO; pop_data shows the head, one-cycle write-to-visible latency.
// Push is refused whenever full, even if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// UART transmitter with input FIFO; frame starts on the first tick after a word is queued.
// in_ready drops when the FIFO is full; frames run back-to-back while words remain.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic [1:0]                        parity_mode,
  input  logic                              stop2,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BC_W  = $clog2(DATA_BITS + 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  frame_cfg_t           cfg_q, cfg_d;
  logic                 tx_q, tx_d;

  logic                 fifo_full, fifo_empty, fifo_pop, start_frame;
  logic [DATA_BITS-1:0] fifo_head;
  logic [CNT_W-1:0]     fifo_cnt;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign in_ready   = !fifo_full;
  assign fifo_count = fifo_cnt;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) || (fifo_cnt != '0);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_d       = par_q;
    cfg_d       = cfg_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          start_frame = !fifo_empty;
        end
        ST_START: begin
          tx_d      = shift_q[0];
          par_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = BC_W'(1);
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == BC_W'(DATA_BITS)) begin
            if (cfg_q.par_en) begin
              tx_d    = par_q ^ cfg_q.par_odd;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            par_d     = par_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (cfg_q.stop2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    // Format is captured only here, so mid-frame config changes wait for the next frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
      cfg_d    = decode_cfg(parity_mode, stop2);
      tx_d     = 1'b0;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      cfg_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      cfg_q      <= cfg_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: 8-bit and 5-bit instances, tick every 16 clocks.
module tb_uart_tx_framed;

  logic       clk, rst, tick, in_valid, in_ready, tx, busy, stop2;
  logic [7:0] in_data;
  logic [1:0] parity_mode;
  logic [2:0] fifo_count;
  logic       in_valid5, in_ready5, tx5, busy5;
  logic [4:0] in_data5;
  logic [2:0] fifo_count5;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accepted;

  uart_tx_framed #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .parity_mode(parity_mode), .stop2(stop2), .tx(tx),
    .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_framed #(.DATA_BITS(5), .FIFO_DEPTH(4)) u_dut5 (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .parity_mode(parity_mode), .stop2(stop2), .tx(tx5),
    .busy(busy5), .fifo_count(fifo_count5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  // One baud period of 16 clocks; tick is high for the last one. A held in_valid is
  // released right after the edge where it handshakes.
  task automatic tick_once();
    logic hs;
    for (int c = 0; c < 16; c++) begin
      tick = (c == 15);
      hs   = in_valid && in_ready;
      @(negedge clk);
      if (hs) begin
        in_valid = 1'b0;
        n_accepted++;
      end
    end
    tick = 1'b0;
  endtask

  task automatic capture(input int n, output logic [63:0] obs, output logic [63:0] obs5);
    obs  = '1;
    obs5 = '1;
    for (int i = 0; i < n; i++) begin
      tick_once();
      obs[i]  = tx;
      obs5[i] = tx5;
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: in_ready stayed 0 for word %h, expected 1 within 64 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid5 = 1'b0; in_data5 = '0; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (tx5 !== 1'b1) begin n_fail++; $display("FAIL reset_tx5: got %b expected 1", tx5); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({tx, busy} !== 2'b10) begin n_fail++; $display("FAIL post_reset_idle: got tx,busy=%b expected 10", {tx, busy}); end
  endtask

  task automatic test_basic_8n1();
    logic [63:0] obs, obs5;
    parity_mode = 2'b00; stop2 = 1'b0;
    write_word(8'hA5);
    n_checks++; if ({busy, fifo_count, tx} !== 5'b1_001_1) begin n_fail++; $display("FAIL queued_before_tick: got busy,count,tx=%b expected 1_001_1", {busy, fifo_count, tx}); end
    capture(10, obs, obs5);
    n_checks++; if (obs[9:0] !== 10'b1_1010_0101_0) begin n_fail++; $display("FAIL frame_8n1_A5: got %b expected %b", obs[9:0], 10'b1_1010_0101_0); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_stop_8n1: got %b expected 1", busy); end
    tick_once();
    n_checks++; if ({busy, tx} !== 2'b01) begin n_fail++; $display("FAIL idle_after_8n1: got busy,tx=%b expected 01", {busy, tx}); end
  endtask

  task automatic test_parity();
    logic [63:0] obs, obs5;
    parity_mode = 2'b01; stop2 = 1'b0;
    write_word(8'h07);
    capture(11, obs, obs5);
    n_checks++; if (obs[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin n_fail++; $display("FAIL frame_even_07: got %b expected %b", obs[10:0], {1'b1, 1'b1, 8'h07, 1'b0}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_tick11_even: got %b expected 1", busy); end
    tick_once();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_even_11: busy got %b expected 0", busy); end

    parity_mode = 2'b10; stop2 = 1'b1;
    write_word(8'h07);
    capture(12, obs, obs5);
    n_checks++; if (obs[11:0] !== {2'b11, 1'b0, 8'h07, 1'b0}) begin n_fail++; $display("FAIL frame_odd2_07: got %b expected %b", obs[11:0], {2'b11, 1'b0, 8'h07, 1'b0}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_tick12_odd2: got %b expected 1", busy); end
    tick_once();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_odd2_12: busy got %b expected 0", busy); end

    parity_mode = 2'b11; stop2 = 1'b0;
    write_word(8'h07);
    capture(10, obs, obs5);
    n_checks++; if (obs[9:0] !== {1'b1, 8'h07, 1'b0}) begin n_fail++; $display("FAIL frame_mode11_none: got %b expected %b", obs[9:0], {1'b1, 8'h07, 1'b0}); end
    tick_once();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_mode11_10: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rest, obs5;
    logic        first;
    logic [49:0] full;
    parity_mode = 2'b00; stop2 = 1'b0;
    write_word(8'h3C); write_word(8'hC3); write_word(8'h5A); write_word(8'h96);
    n_checks++; if ({in_ready, fifo_count} !== 4'b0_100) begin n_fail++; $display("FAIL fifo_full: got in_ready,count=%b expected 0_100", {in_ready, fifo_count}); end
    n_accepted = 0;
    in_data = 8'h0F; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_holds: count got %0d expected 4", fifo_count); end
    tick_once();
    first = tx;
    n_checks++; if ({fifo_count, n_accepted[0]} !== 4'b011_0) begin n_fail++; $display("FAIL push_refused_on_pop: got count,acc=%b expected 011_0", {fifo_count, n_accepted[0]}); end
    capture(49, rest, obs5);
    full = {rest[48:0], first};
    n_checks++; if (full !== {1'b1, 8'h0F, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL back_to_back_5: got %b expected %b", full,
        {1'b1, 8'h0F, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0});
    end
    n_checks++; if (n_accepted !== 1) begin n_fail++; $display("FAIL fifth_accepted: got %0d expected 1", n_accepted); end
    tick_once();
    n_checks++; if ({busy, fifo_count} !== 4'b0_000) begin n_fail++; $display("FAIL idle_after_burst: got busy,count=%b expected 0_000", {busy, fifo_count}); end
  endtask

  task automatic test_cfg_midframe();
    logic [63:0] rest, obs5;
    logic        first;
    logic [22:0] full;
    parity_mode = 2'b01; stop2 = 1'b0;
    write_word(8'h07); write_word(8'h81);
    tick_once();
    first = tx;
    parity_mode = 2'b10; stop2 = 1'b1;
    capture(22, rest, obs5);
    full = {rest[21:0], first};
    n_checks++; if (full !== {2'b11, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0}) begin
      n_fail++; $display("FAIL cfg_latched: got %b expected %b", full, {2'b11, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0});
    end
    tick_once();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_cfg: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] obs, obs5;
    parity_mode = 2'b00; stop2 = 1'b0;
    write_word(8'h00); write_word(8'hFF);
    capture(3, obs, obs5);
    n_checks++; if ({tx, busy, fifo_count} !== 5'b0_1_001) begin n_fail++; $display("FAIL pre_abort_data: got tx,busy,count=%b expected 0_1_001", {tx, busy, fifo_count}); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({tx, busy, fifo_count, in_ready} !== 6'b1_0_000_1) begin n_fail++; $display("FAIL async_abort: got tx,busy,count,rdy=%b expected 1_0_000_1", {tx, busy, fifo_count, in_ready}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    write_word(8'h5A);
    capture(10, obs, obs5);
    n_checks++; if (obs[9:0] !== {1'b1, 8'h5A, 1'b0}) begin n_fail++; $display("FAIL clean_after_reset: got %b expected %b", obs[9:0], {1'b1, 8'h5A, 1'b0}); end
    tick_once();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset_frame: busy got %b expected 0", busy); end
  endtask

  task automatic test_data5();
    logic [63:0] obs, obs5;
    parity_mode = 2'b00; stop2 = 1'b0;
    in_data5 = 5'h1F; in_valid5 = 1'b1;
    n_checks++; if (in_ready5 !== 1'b1) begin n_fail++; $display("FAIL ready5: got %b expected 1", in_ready5); end
    @(negedge clk);
    in_valid5 = 1'b0;
    n_checks++; if (fifo_count5 !== 3'd1) begin n_fail++; $display("FAIL count5: got %0d expected 1", fifo_count5); end
    capture(7, obs, obs5);
    n_checks++; if (obs5[6:0] !== 7'b1_11111_0) begin n_fail++; $display("FAIL frame5_1F: got %b expected 1111110", obs5[6:0]); end
    tick_once();
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("FAIL len5_7: busy5 got %b expected 0", busy5); end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_cfg_midframe();
    test_reset_midframe();
    test_data5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
